// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush arbiter with shared-divider handshake FSM
// Optional stall watchdog: define PIPE_STALL_WATCHDOG_EN to build it in.
module pipeline_ctrl #(
  parameter int WDOG_LIMIT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stallreq_id,
  input  logic       stallreq_ex,
  input  logic       stallreq_mem,
  input  logic       div_req,
  input  logic       div_ready,
  input  logic       div_annul,
  input  logic       flush_req,
  output logic [5:0] stall,
  output logic       div_start,
  output logic       div_busy,
  output logic       flush,
  output logic       wdog_err
);

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_START = 2'd1,
    DIV_BUSY  = 2'd2,
    DIV_DONE  = 2'd3
  } div_state_t;

  div_state_t state_q;
  div_state_t state_d;
  logic       div_stall;
  logic       ex_cause;
  logic       div_start_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DIV_IDLE;
      div_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_start_q <= (state_d == DIV_START);
    end
  end

  // DONE deliberately ignores div_req so the finished divide leaves EX.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: begin
        if (div_req && !flush_req) state_d = DIV_START;
      end
      DIV_START: begin
        if (flush_req || div_annul) state_d = DIV_IDLE;
        else                        state_d = DIV_BUSY;
      end
      DIV_BUSY: begin
        if (flush_req || div_annul) state_d = DIV_IDLE;
        else if (div_ready)         state_d = DIV_DONE;
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  assign div_stall = ((state_q == DIV_IDLE) && div_req)
                   || (state_q == DIV_START)
                   || (state_q == DIV_BUSY);
  assign ex_cause  = stallreq_ex || div_stall;
  assign div_start = div_start_q;
  assign div_busy  = (state_q != DIV_IDLE);

  always_comb begin
    stall = 6'b000000;
    flush = 1'b0;
    if (!rst) begin
      flush = flush_req;
      if (flush_req)         stall = 6'b000000;
      else if (stallreq_mem) stall = 6'b011111;
      else if (ex_cause)     stall = 6'b001111;
      else if (stallreq_id)  stall = 6'b000111;
    end
  end

`ifdef PIPE_STALL_WATCHDOG_EN
  localparam int CNT_W = $clog2(WDOG_LIMIT + 1);

  logic [CNT_W-1:0] wdog_cnt;
  logic             wdog_err_q;

  // Counter saturates at the limit; the error is flagged one cycle after it gets there.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt   <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (!stall[0])                          wdog_cnt <= '0;
      else if (wdog_cnt != CNT_W'(WDOG_LIMIT)) wdog_cnt <= wdog_cnt + CNT_W'(1);
      if (wdog_cnt == CNT_W'(WDOG_LIMIT))     wdog_err_q <= 1'b1;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  logic unused_wdog_limit;
  assign unused_wdog_limit = ^WDOG_LIMIT;
  assign wdog_err          = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       stallreq_id, stallreq_ex, stallreq_mem;
  logic       div_req, div_ready, div_annul, flush_req;
  logic [5:0] stall;
  logic       div_start, div_busy, flush, wdog_err;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.WDOG_LIMIT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .div_req      (div_req),
    .div_ready    (div_ready),
    .div_annul    (div_annul),
    .flush_req    (flush_req),
    .stall        (stall),
    .div_start    (div_start),
    .div_busy     (div_busy),
    .flush        (flush),
    .wdog_err     (wdog_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    stallreq_id  = 1'b0;
    stallreq_ex  = 1'b0;
    stallreq_mem = 1'b0;
    div_req      = 1'b0;
    div_ready    = 1'b0;
    div_annul    = 1'b0;
    flush_req    = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;

    // Reset: outputs forced low even with requests pending
    div_req = 1'b1; stallreq_mem = 1'b1; flush_req = 1'b1;
    tick(); tick();
    check("rst_stall", stall, 6'b000000);
    check("rst_flush", {5'b0, flush}, 6'd0);
    check("rst_busy", {5'b0, div_busy}, 6'd0);
    check("rst_start", {5'b0, div_start}, 6'd0);
    check("rst_wdog", {5'b0, wdog_err}, 6'd0);
    clear_inputs();
    rst = 1'b0;
    tick();
    check("idle_stall", stall, 6'b000000);

    // Stall priority, all within one cycle
    stallreq_id = 1'b1; #1;
    check("id_only", stall, 6'b000111);
    stallreq_mem = 1'b1; #1;
    check("id_mem", stall, 6'b011111);
    flush_req = 1'b1; #1;
    check("flush_stall", stall, 6'b000000);
    check("flush_out", {5'b0, flush}, 6'd1);
    clear_inputs(); stallreq_ex = 1'b1; #1;
    check("ex_only", stall, 6'b001111);
    stallreq_id = 1'b1; #1;
    check("ex_over_id", stall, 6'b001111);
    clear_inputs();

    // div_ready in IDLE is ignored
    tick();
    div_ready = 1'b1;
    tick();
    check("ready_idle_busy", {5'b0, div_busy}, 6'd0);
    div_ready = 1'b0;

    // Full divide: ready pulsed 5 cycles after div_start
    div_req = 1'b1; #1;
    check("div_idle_stall", stall, 6'b001111);
    check("div_idle_busy", {5'b0, div_busy}, 6'd0);
    tick();
    check("div_start_hi", {5'b0, div_start}, 6'd1);
    check("div_start_busy", {5'b0, div_busy}, 6'd1);
    check("div_start_stall", stall, 6'b001111);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("div_busy_start", {5'b0, div_start}, 6'd0);
      check("div_busy_stall", stall, 6'b001111);
    end
    tick();
    div_ready = 1'b1; #1;
    check("div_ready_stall", stall, 6'b001111);
    tick();
    div_ready = 1'b0; #1;
    check("done_stall", stall, 6'b000000);
    check("done_busy", {5'b0, div_busy}, 6'd1);
    tick();
    check("after_done_busy", {5'b0, div_busy}, 6'd0);
    div_req = 1'b0; #1;
    check("after_done_stall", stall, 6'b000000);

    // Annul together with ready in BUSY
    div_req = 1'b1;
    tick(); tick();
    check("annul_pre_busy", {5'b0, div_busy}, 6'd1);
    div_annul = 1'b1; div_ready = 1'b1;
    tick();
    check("annul_idle", {5'b0, div_busy}, 6'd0);
    clear_inputs(); #1;
    check("annul_stall", stall, 6'b000000);

    // Flush in START, and flush blocking IDLE->START
    div_req = 1'b1;
    tick();
    check("fl_start", {5'b0, div_start}, 6'd1);
    flush_req = 1'b1;
    tick();
    check("fl_start_idle", {5'b0, div_busy}, 6'd0);
    tick();
    check("fl_blocks_start", {5'b0, div_busy}, 6'd0);
    clear_inputs();

    // Reset in BUSY
    div_req = 1'b1;
    tick(); tick();
    check("rstb_pre_busy", {5'b0, div_busy}, 6'd1);
    rst = 1'b1; flush_req = 1'b1; #1;
    check("rstb_stall", stall, 6'b000000);
    check("rstb_flush", {5'b0, flush}, 6'd0);
    flush_req = 1'b0;
    tick();
    check("rstb_busy", {5'b0, div_busy}, 6'd0);
    check("rstb_start", {5'b0, div_start}, 6'd0);
    check("rstb_stall2", stall, 6'b000000);
    tick();
    check("rstb_start2", {5'b0, div_start}, 6'd0);
    rst = 1'b0;
    clear_inputs();
    tick();

`ifdef PIPE_STALL_WATCHDOG_EN
    stallreq_id = 1'b1;
    repeat (8) tick();
    check("wd8_not_yet", {5'b0, wdog_err}, 6'd0);
    stallreq_id = 1'b0;
    tick();
    check("wd8_set", {5'b0, wdog_err}, 6'd1);
    repeat (3) tick();
    check("wd8_sticky", {5'b0, wdog_err}, 6'd1);
    rst = 1'b1;
    tick();
    check("wd_rst_clear", {5'b0, wdog_err}, 6'd0);
    rst = 1'b0;
    stallreq_id = 1'b1;
    repeat (7) tick();
    stallreq_id = 1'b0;
    repeat (3) tick();
    check("wd7_clear", {5'b0, wdog_err}, 6'd0);
`else
    stallreq_id = 1'b1;
    repeat (100) tick();
    check("wd_off_held", {5'b0, wdog_err}, 6'd0);
    stallreq_id = 1'b0;
    tick();
    check("wd_off_after", {5'b0, wdog_err}, 6'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
